mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, bus cycles allowed per access before abort; range 2..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 if_ce_i  in  1  instruction-fetch read request; if_addr_i  in  32  fetch address.
REQ-005 if_data_o  out  32  fetched word; if_ready_o  out  1  fetch served, data valid.
REQ-006 mem_ce_i  in  1  data request; mem_we_i  in  1  write; mem_sel_i  in  4  byte lanes; mem_addr_i  in  32; mem_data_i  in  32  store data.
REQ-007 mem_data_o  out  32  load data; mem_ready_o  out  1  data access served.
REQ-008 bus_req_o  out  1; bus_we_o  out  1; bus_sel_o  out  4; bus_addr_o  out  32; bus_wdata_o  out  32  shared memory port.
REQ-009 bus_rdata_i  in  32; bus_ack_i  in  1  memory completion, one cycle.
REQ-010 stallreq_o  out  1  pipeline stall request; bus_err_o  out  1  access timeout pulse.

Function
REQ-011 FSM states: IDLE, BUSY_D (data access), BUSY_I (fetch access).
REQ-012 Per-port served flags srv_d, srv_i; if_ready_o = srv_i, mem_ready_o = srv_d.
REQ-013 Pending: pend_d = mem_ce_i & ~srv_d; pend_i = if_ce_i & ~srv_i.
REQ-014 stallreq_o = pend_d | pend_i, combinational.
REQ-015 IDLE: pend_d -> BUSY_D; else pend_i -> BUSY_I; else stay; data port has fixed priority.
REQ-016 On IDLE->BUSY_x, register the selected port's addr/we/sel/wdata; fetch drives we=0, sel=4'b1111, wdata=0.
REQ-017 bus_req_o = 1 exactly in BUSY_D/BUSY_I; bus_* fields held stable until ack or abort.
REQ-018 bus_ack_i in BUSY_x: capture bus_rdata_i into x data register (writes capture 0), set srv_x, -> IDLE; total latency request-to-ready = ack cycle + 1.
REQ-019 bus_ack_i in IDLE is ignored.
REQ-020 When stallreq_o = 0 at a rising edge, clear srv_d and srv_i (pipeline advanced); data registers keep value.
REQ-021 Both ports requesting: data served first, stall held, fetch served next, one bubble (IDLE) between accesses.
REQ-022 Requester dropping ce while its access is in BUSY: access completes, result discarded on next flag clear.

Reset
REQ-023 rst low: state IDLE, srv_d = srv_i = 0, data registers 0, bus_req_o = 0, bus_we_o = 0, bus_sel_o = 0, bus_addr_o = 0, bus_wdata_o = 0, bus_err_o = 0, timeout counter 0; effective immediately, including mid-access.
REQ-024 After release, first request is arbitered at the first rising edge with rst high.

Configuration
REQ-025 Macro MEM_BUS_ARBITER_TIMEOUT_EN defined: 8-bit counter cleared on entering BUSY, increments each BUSY cycle; at count TIMEOUT_CYCLES-1 without ack: drop bus_req_o, set srv_x with data 0, pulse bus_err_o one cycle, -> IDLE.
REQ-026 Ack in the same cycle as expiry: ack wins, no bus_err_o.
REQ-027 Macro undefined: no counter, BUSY waits indefinitely, bus_err_o tied 0.

Verification
REQ-028 mem_ce_i=1, we=0, addr=0x100; ack 3 cycles later with rdata=0xDEADBEEF -> bus_req_o 3 cycles, mem_ready_o=1 and mem_data_o=0xDEADBEEF next cycle, stallreq_o=0 that cycle.
REQ-029 if_ce_i and mem_ce_i (sw, addr 0x200, data 0x12345678, sel 1111) same cycle, ack=1 cycle each -> data write first, then fetch; stallreq_o high until both ready, then both flags cleared.
REQ-030 rst low while BUSY_I with bus_req_o=1 -> bus_req_o=0 same cycle, state IDLE, no ready pulse.
REQ-031 TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req_o 4 cycles, bus_err_o one-cycle pulse, mem_ready_o=1 with data 0.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=4, ack on 4th BUSY cycle -> normal completion, bus_err_o stays 0.
REQ-033 Stray bus_ack_i pulse in IDLE with no requests -> no state change, ready outputs stay 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port (data/fetch) arbiter onto one shared memory bus, data port first.
// Optional access timeout is enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES out of range 2..255");
  end

  state_t      state, state_nxt;
  logic        srv_d, srv_i;
  logic        pend_d, pend_i;
  logic        done, tmo;
  logic [31:0] d_data, i_data;

  assign pend_d      = mem_ce_i & ~srv_d;
  assign pend_i      = if_ce_i & ~srv_i;
  assign stallreq_o  = pend_d | pend_i;
  assign mem_ready_o = srv_d;
  assign if_ready_o  = srv_i;
  assign mem_data_o  = d_data;
  assign if_data_o   = i_data;
  assign bus_req_o   = (state != IDLE);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;
  assign bus_err_o = err_q;
`else
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (pend_d)      state_nxt = BUSY_D;
        else if (pend_i) state_nxt = BUSY_I;
      end
      BUSY_D, BUSY_I: begin
        if (bus_ack_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srv_d       <= 1'b0;
      srv_i       <= 1'b0;
      d_data      <= '0;
      i_data      <= '0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      // Pipeline advanced: drop served flags; a completion this cycle still sets its flag below.
      if (!stallreq_o) begin
        srv_d <= 1'b0;
        srv_i <= 1'b0;
      end
      if (state == IDLE && pend_d) begin
        bus_we_o    <= mem_we_i;
        bus_sel_o   <= mem_sel_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_data_i;
      end else if (state == IDLE && pend_i) begin
        bus_we_o    <= 1'b0;
        bus_sel_o   <= 4'b1111;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
      end
      if (done || tmo) begin
        if (state == BUSY_D) begin
          srv_d  <= 1'b1;
          d_data <= (done && !bus_we_o) ? bus_rdata_i : 32'h0;
        end else begin
          srv_i  <= 1'b1;
          i_data <= done ? bus_rdata_i : 32'h0;
        end
      end
    end
  end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= (state == IDLE) ? 8'd0 : cnt + 8'd1;
      err_q <= tmo;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic        bus_err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; if_ce_i = 0; if_addr_i = 0; mem_ce_i = 0; mem_we_i = 0;
    mem_sel_i = 0; mem_addr_i = 0; mem_data_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    tick(); tick();
    chk("rst_bus_req", 32'(bus_req_o), 32'd0);
    chk("rst_stall", 32'(stallreq_o), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready_o), 32'd0);
    chk("rst_if_ready", 32'(if_ready_o), 32'd0);
    chk("rst_bus_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    rst = 1'b1;

    // single data read, ack on third bus cycle
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h100; mem_sel_i = 4'hF;
    #1 chk("rd_stall_req", 32'(stallreq_o), 32'd1);
    tick();
    chk("rd_bus_req1", 32'(bus_req_o), 32'd1);
    chk("rd_bus_addr", bus_addr_o, 32'h100);
    chk("rd_bus_we", 32'(bus_we_o), 32'd0);
    tick();
    chk("rd_bus_req2", 32'(bus_req_o), 32'd1);
    tick();
    chk("rd_bus_req3", 32'(bus_req_o), 32'd1);
    bus_ack_i = 1; bus_rdata_i = 32'hDEADBEEF;
    tick();
    bus_ack_i = 0;
    chk("rd_ready", 32'(mem_ready_o), 32'd1);
    chk("rd_data", mem_data_o, 32'hDEADBEEF);
    chk("rd_stall_done", 32'(stallreq_o), 32'd0);
    chk("rd_bus_req_off", 32'(bus_req_o), 32'd0);
    mem_ce_i = 0;
    tick();
    chk("rd_ready_clr", 32'(mem_ready_o), 32'd0);
    chk("rd_data_hold", mem_data_o, 32'hDEADBEEF);

    // simultaneous write + fetch
    if_ce_i = 1; if_addr_i = 32'h400;
    mem_ce_i = 1; mem_we_i = 1; mem_sel_i = 4'hF; mem_addr_i = 32'h200; mem_data_i = 32'h12345678;
    #1 chk("both_stall", 32'(stallreq_o), 32'd1);
    tick();
    chk("wr_bus_we", 32'(bus_we_o), 32'd1);
    chk("wr_bus_addr", bus_addr_o, 32'h200);
    chk("wr_bus_wdata", bus_wdata_o, 32'h12345678);
    chk("wr_bus_sel", 32'(bus_sel_o), 32'hF);
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA5555;
    tick();
    bus_ack_i = 0;
    chk("wr_ready", 32'(mem_ready_o), 32'd1);
    chk("wr_data_zero", mem_data_o, 32'd0);
    chk("wr_stall_held", 32'(stallreq_o), 32'd1);
    chk("bubble_no_req", 32'(bus_req_o), 32'd0);
    tick();
    chk("if_bus_req", 32'(bus_req_o), 32'd1);
    chk("if_bus_addr", bus_addr_o, 32'h400);
    chk("if_bus_we", 32'(bus_we_o), 32'd0);
    chk("if_bus_sel", 32'(bus_sel_o), 32'hF);
    chk("if_bus_wdata", bus_wdata_o, 32'd0);
    chk("wr_ready_kept", 32'(mem_ready_o), 32'd1);
    bus_ack_i = 1; bus_rdata_i = 32'hCAFEF00D;
    tick();
    bus_ack_i = 0;
    chk("if_ready", 32'(if_ready_o), 32'd1);
    chk("if_data", if_data_o, 32'hCAFEF00D);
    chk("both_mem_ready", 32'(mem_ready_o), 32'd1);
    chk("both_stall_off", 32'(stallreq_o), 32'd0);
    if_ce_i = 0; mem_ce_i = 0; mem_we_i = 0;
    tick();
    chk("both_if_clr", 32'(if_ready_o), 32'd0);
    chk("both_mem_clr", 32'(mem_ready_o), 32'd0);

    // reset mid fetch
    if_ce_i = 1; if_addr_i = 32'h800;
    tick();
    chk("mid_bus_req", 32'(bus_req_o), 32'd1);
    rst = 0; if_ce_i = 0;
    #1;
    chk("mid_rst_req", 32'(bus_req_o), 32'd0);
    chk("mid_rst_addr", bus_addr_o, 32'd0);
    chk("mid_rst_ready", 32'(if_ready_o), 32'd0);
    tick();
    rst = 1;
    tick();
    chk("post_rst_ready", 32'(if_ready_o), 32'd0);
    chk("post_rst_req", 32'(bus_req_o), 32'd0);

    // stray ack in IDLE
    bus_ack_i = 1; bus_rdata_i = 32'h11111111;
    tick();
    bus_ack_i = 0;
    chk("stray_mem_ready", 32'(mem_ready_o), 32'd0);
    chk("stray_if_ready", 32'(if_ready_o), 32'd0);
    chk("stray_bus_req", 32'(bus_req_o), 32'd0);
    chk("stray_mem_data", mem_data_o, 32'd0);

    // requester drops ce during its access
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h300;
    tick();
    mem_ce_i = 0;
    #1 chk("drop_stall", 32'(stallreq_o), 32'd0);
    chk("drop_bus_req", 32'(bus_req_o), 32'd1);
    bus_ack_i = 1; bus_rdata_i = 32'h0BADF00D;
    tick();
    bus_ack_i = 0;
    chk("drop_ready", 32'(mem_ready_o), 32'd1);
    chk("drop_data", mem_data_o, 32'h0BADF00D);
    tick();
    chk("drop_ready_clr", 32'(mem_ready_o), 32'd0);

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    // timeout without ack
    mem_ce_i = 1; mem_addr_i = 32'h500;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tmo_bus_req", 32'(bus_req_o), 32'd1);
      chk("tmo_err_early", 32'(bus_err_o), 32'd0);
    end
    tick();
    chk("tmo_bus_req_off", 32'(bus_req_o), 32'd0);
    chk("tmo_err", 32'(bus_err_o), 32'd1);
    chk("tmo_ready", 32'(mem_ready_o), 32'd1);
    chk("tmo_data", mem_data_o, 32'd0);
    mem_ce_i = 0;
    tick();
    chk("tmo_err_pulse", 32'(bus_err_o), 32'd0);
    chk("tmo_ready_clr", 32'(mem_ready_o), 32'd0);

    // ack on the last allowed cycle
    mem_ce_i = 1; mem_addr_i = 32'h600;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("late_bus_req", 32'(bus_req_o), 32'd1);
    end
    bus_ack_i = 1; bus_rdata_i = 32'h13572468;
    tick();
    bus_ack_i = 0; mem_ce_i = 0;
    chk("late_ready", 32'(mem_ready_o), 32'd1);
    chk("late_data", mem_data_o, 32'h13572468);
    chk("late_no_err", 32'(bus_err_o), 32'd0);
    tick();
    chk("late_no_err2", 32'(bus_err_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
